// File: rtl/if_stage_bht.sv
// rtl/if_stage_bht.sv - fetch stage: PC register, B-type/JAL prediction, 2-bit saturating BHT
// Define IF_PERF_CNT_EN to add the pred_cnt_o / mispred_cnt_o performance counters.
module if_stage_bht #(
   parameter int unsigned BHT_DEPTH = 64,
   parameter logic [31:0] RESET_PC  = 32'h0,
   parameter logic [1:0]  BHT_INIT  = 2'b01,
   parameter int unsigned CNT_W     = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             stall_i,
   input  logic [31:0]      instruction_i,
   input  logic             resolve_valid_i,
   input  logic [31:0]      resolve_pc_i,
   input  logic             resolve_taken_i,
   input  logic             resolve_mispred_i,
   input  logic [31:0]      resolve_target_i,
   output logic [31:0]      pc_o,
   output logic             br_pred_o,
   output logic [31:0]      new_pc_pred_o
`ifdef IF_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] pred_cnt_o,
   output logic [CNT_W-1:0] mispred_cnt_o
`endif
);
   localparam int unsigned IDX_W     = $clog2(BHT_DEPTH);
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam logic [6:0]  OP_JAL    = 7'b1101111;

   logic [31:0]      pc_q, pc_d;
   logic [1:0]       bht_q [BHT_DEPTH];
   logic [1:0]       upd_cnt_d;
   logic [IDX_W-1:0] rd_idx, wr_idx;
   logic [31:0]      imm_b, imm_j, target;
   logic             redirect;
   logic             unused_resolve_pc;

   assign rd_idx            = pc_q[IDX_W+1:2];
   assign wr_idx            = resolve_pc_i[IDX_W+1:2];
   assign unused_resolve_pc = ^{resolve_pc_i[31:IDX_W+2], resolve_pc_i[1:0]};
   assign redirect          = resolve_valid_i & resolve_mispred_i;
   assign pc_o              = pc_q;

   assign imm_b = {{20{instruction_i[31]}}, instruction_i[7], instruction_i[30:25],
                   instruction_i[11:8], 1'b0};
   assign imm_j = {{12{instruction_i[31]}}, instruction_i[19:12], instruction_i[20],
                   instruction_i[30:21], 1'b0};

   always_comb begin
      br_pred_o = 1'b0;
      target    = pc_q + imm_b;
      case (instruction_i[6:0])
         OP_BRANCH: br_pred_o = bht_q[rd_idx][1];
         OP_JAL: begin
            br_pred_o = 1'b1;
            target    = pc_q + imm_j;
         end
         default: ;
      endcase
      new_pc_pred_o = br_pred_o ? target : pc_q + 32'd4;
   end

   // A redirect from execute wins over a stall so a wrong path is never held.
   always_comb begin
      pc_d = new_pc_pred_o;
      if (redirect)
         pc_d = resolve_target_i;
      else if (stall_i)
         pc_d = pc_q;
   end

   always_comb begin
      upd_cnt_d = bht_q[wr_idx];
      if (resolve_taken_i) begin
         if (upd_cnt_d != 2'b11) upd_cnt_d = upd_cnt_d + 2'd1;
      end else begin
         if (upd_cnt_d != 2'b00) upd_cnt_d = upd_cnt_d - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pc_q <= RESET_PC;
      else          pc_q <= pc_d;
   end

   // Prediction reads bht_q combinationally, so a same-cycle update is seen next cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(BHT_DEPTH); i++) bht_q[i] <= BHT_INIT;
      end else if (resolve_valid_i) begin
         bht_q[wr_idx] <= upd_cnt_d;
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [CNT_W-1:0] pred_cnt_q, mispred_cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pred_cnt_q    <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (!stall_i && br_pred_o && !redirect) pred_cnt_q <= pred_cnt_q + 1'b1;
         if (redirect) mispred_cnt_q <= mispred_cnt_q + 1'b1;
      end
   end

   assign pred_cnt_o    = pred_cnt_q;
   assign mispred_cnt_o = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage_bht.sv
// tb/tb_if_stage_bht.sv - self-checking bench for if_stage_bht (table vectors, corner sequences, random vs model)
module tb_if_stage_bht;
   localparam int DEPTH = 64;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        stall_i;
   logic [31:0] instruction_i;
   logic        resolve_valid_i;
   logic [31:0] resolve_pc_i;
   logic        resolve_taken_i;
   logic        resolve_mispred_i;
   logic [31:0] resolve_target_i;
   logic [31:0] pc_o;
   logic        br_pred_o;
   logic [31:0] new_pc_pred_o;
`ifdef IF_PERF_CNT_EN
   logic [31:0] pred_cnt_o, mispred_cnt_o;
`endif

   if_stage_bht dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .stall_i           (stall_i),
      .instruction_i     (instruction_i),
      .resolve_valid_i   (resolve_valid_i),
      .resolve_pc_i      (resolve_pc_i),
      .resolve_taken_i   (resolve_taken_i),
      .resolve_mispred_i (resolve_mispred_i),
      .resolve_target_i  (resolve_target_i),
      .pc_o              (pc_o),
      .br_pred_o         (br_pred_o),
      .new_pc_pred_o     (new_pc_pred_o)
`ifdef IF_PERF_CNT_EN
      ,
      .pred_cnt_o        (pred_cnt_o),
      .mispred_cnt_o     (mispred_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [31:0] pc_m;
   int          bht_m [DEPTH];
   logic [31:0] pred_m, misp_m;

   // Last sampled DUT values, for table/sequence checks against constants
   logic        act_pred;
   logic [31:0] act_npc, act_pc;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [31:0] ins;
      logic        pred;
      logic [31:0] npc;
   } vec_t;
   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] enc_b(input int imm);
      logic [12:0] i;
      i = imm[12:0];
      return {i[12], i[10:5], 5'd2, 5'd1, 3'b000, i[4:1], i[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input int imm);
      logic [20:0] i;
      i = imm[20:0];
      return {i[20], i[10:1], i[11], i[19:12], 5'd1, 7'b1101111};
   endfunction

   function automatic void model_reset();
      pc_m = 32'h0;
      for (int i = 0; i < DEPTH; i++) bht_m[i] = 1;
      pred_m = 0;
      misp_m = 0;
   endfunction

   // Immediates rebuilt from their field weights with integer arithmetic.
   function automatic void model_predict(input logic [31:0] pc, input logic [31:0] ins,
                                         output logic p, output logic [31:0] npc);
      int unsigned w;
      int op, imm;
      w  = ins;
      op = int'(w % 128);
      p  = 1'b0;
      npc = pc + 32'd4;
      if (op == 99) begin
         imm = ((w >> 31) != 0 ? -4096 : 0) + int'((w >> 7) & 1) * 2048
             + int'((w >> 25) & 63) * 32 + int'((w >> 8) & 15) * 2;
         p = (bht_m[(pc >> 2) % DEPTH] >= 2);
         if (p) npc = pc + imm;
      end else if (op == 111) begin
         imm = ((w >> 31) != 0 ? -1048576 : 0) + int'((w >> 12) & 255) * 4096
             + int'((w >> 20) & 1) * 2048 + int'((w >> 21) & 1023) * 2;
         p = 1'b1;
         npc = pc + imm;
      end
   endfunction

   // One clock: called and returns at a negedge.
   task automatic cycle(input logic st, input logic [31:0] ins, input logic rv,
                        input logic [31:0] rpc, input logic rt, input logic rm,
                        input logic [31:0] rtgt);
      logic        ep;
      logic [31:0] en;
      int          k;
      stall_i = st; instruction_i = ins; resolve_valid_i = rv; resolve_pc_i = rpc;
      resolve_taken_i = rt; resolve_mispred_i = rm; resolve_target_i = rtgt;
      #1;
      model_predict(pc_m, ins, ep, en);
      act_pred = br_pred_o;
      act_npc  = new_pc_pred_o;
      check("br_pred_o", {31'b0, br_pred_o}, {31'b0, ep});
      check("new_pc_pred_o", new_pc_pred_o, en);
`ifdef IF_PERF_CNT_EN
      check("pred_cnt_o", pred_cnt_o, pred_m);
      check("mispred_cnt_o", mispred_cnt_o, misp_m);
`endif
      @(posedge clk);
      if (!st && ep && !(rv && rm)) pred_m = pred_m + 1;
      if (rv && rm) misp_m = misp_m + 1;
      if (rv && rm) pc_m = rtgt;
      else if (!st) pc_m = en;
      if (rv) begin
         k = int'((rpc >> 2) % DEPTH);
         if (rt) bht_m[k] = (bht_m[k] == 3) ? 3 : bht_m[k] + 1;
         else    bht_m[k] = (bht_m[k] == 0) ? 0 : bht_m[k] - 1;
      end
      @(negedge clk);
      act_pc = pc_o;
      check("pc_o", pc_o, pc_m);
   endtask

   task automatic goto_pc(input logic [31:0] pc);
      cycle(1'b0, NOP, 1'b1, 32'hFC, 1'b0, 1'b1, pc);
   endtask

   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1;
      check("reset_pc_async", pc_o, 32'h0);
      model_reset();
      instruction_i = enc_b(16);
      resolve_valid_i = 1'b0;
      resolve_mispred_i = 1'b0;
      #1;
      check("reset_bpred", {31'b0, br_pred_o}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0; stall_i = 1'b0; instruction_i = enc_b(16);
      resolve_valid_i = 1'b0; resolve_pc_i = '0; resolve_taken_i = 1'b0;
      resolve_mispred_i = 1'b0; resolve_target_i = '0;
      model_reset();
      #1;
      check("rst_pc", pc_o, 32'h0);
      check("rst_bpred", {31'b0, br_pred_o}, 32'h0);
      check("rst_npc", new_pc_pred_o, 32'h4);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      vecs[0] = '{"b_untrained", 32'h100,      enc_b(16),   1'b0, 32'h104};
      vecs[1] = '{"jal_fwd",     32'h100,      enc_j(32),   1'b1, 32'h120};
      vecs[2] = '{"jalr",        32'h100,      32'h0000_8067, 1'b0, 32'h104};
      vecs[3] = '{"alu",         32'h100,      32'h0010_0033, 1'b0, 32'h104};
      vecs[4] = '{"jal_back",    32'h200,      enc_j(-8),   1'b1, 32'h1F8};
      vecs[5] = '{"jal_wrap",    32'hFFFFFFF0, enc_j(32),   1'b1, 32'h10};
      vecs[6] = '{"pc4_wrap",    32'hFFFFFFFC, NOP,         1'b0, 32'h0};
      for (int v = 0; v < 7; v++) begin
         goto_pc(vecs[v].pc);
         cycle(1'b0, vecs[v].ins, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
         check({vecs[v].name, "_pred"}, {31'b0, act_pred}, {31'b0, vecs[v].pred});
         check({vecs[v].name, "_npc"}, act_npc, vecs[v].npc);
         check({vecs[v].name, "_pc"}, act_pc, vecs[v].npc);
      end

      // Training: two taken updates at 0x40 make the B-type predict taken
      repeat (2) cycle(1'b1, NOP, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0);
      goto_pc(32'h40);
      cycle(1'b1, enc_b(16), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      check("train_pred", {31'b0, act_pred}, 32'h1);
      check("train_npc", act_npc, 32'h50);

      // Saturation: 5 taken, 1 not-taken -> 10 (taken); one more -> 01 (not taken)
      repeat (5) cycle(1'b1, NOP, 1'b1, 32'h80, 1'b1, 1'b0, 32'h0);
      cycle(1'b1, NOP, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
      goto_pc(32'h80);
      cycle(1'b1, enc_b(-8), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      check("sat_pred_taken", {31'b0, act_pred}, 32'h1);
      check("sat_npc", act_npc, 32'h78);
      cycle(1'b1, NOP, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
      cycle(1'b1, enc_b(-8), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      check("sat_pred_nt", {31'b0, act_pred}, 32'h0);

      // Redirect overrides stall; stall alone holds
      cycle(1'b1, NOP, 1'b1, 32'hFC, 1'b0, 1'b1, 32'h200);
      check("redir_over_stall", act_pc, 32'h200);
      cycle(1'b1, NOP, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      check("stall_hold", act_pc, 32'h200);
      cycle(1'b1, NOP, 1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
      check("mispred_no_valid", act_pc, 32'h200);

      // Same-cycle update and read at idx 3
      goto_pc(32'h0C);
      cycle(1'b1, enc_b(8), 1'b1, 32'h0C, 1'b1, 1'b0, 32'h0);
      check("same_cycle_old", {31'b0, act_pred}, 32'h0);
      cycle(1'b1, enc_b(8), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      check("same_cycle_new", {31'b0, act_pred}, 32'h1);
      check("same_cycle_npc", act_npc, 32'h14);

      // Mid-run asynchronous reset
      do_reset();
      cycle(1'b0, enc_b(16), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      check("post_reset_pc", act_pc, 32'h4);

      for (int n = 0; n < 3000; n++) begin
         logic [31:0] ins;
         int r;
         r = int'($urandom_range(0, 3));
         if (r <= 1)      ins = enc_b(int'($urandom_range(0, 4095)) * 2 - 4096);
         else if (r == 2) ins = enc_j(int'($urandom_range(0, 1048575)) * 2 - 1048576);
         else begin
            ins = $urandom();
            ins[6:0] = ($urandom_range(0, 1) != 0) ? 7'h67 : 7'h33;
         end
         cycle($urandom_range(0, 3) == 0, ins, $urandom_range(0, 1) == 1,
               32'($urandom_range(0, 255)) << 2, $urandom_range(0, 1) == 1,
               $urandom_range(0, 3) == 0, 32'($urandom_range(0, 1023)) << 2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
